// File: rtl/muldiv_hilo_if.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_if
// Issue/result bundle between the control unit (master) and the HI/LO
// multiply/divide unit (slave).
//
//   start      master -> slave  issue request, sampled only while the unit idles
//   op         master -> slave  2'b01 multiply, 2'b10 divide, others no-op
//   is_signed  master -> slave  signed operation request (SIGNED_MULDIV_EN builds)
//   rs_data    master -> slave  multiplicand / dividend (register file RD1)
//   rt_data    master -> slave  multiplier / divisor   (register file RD2)
//   busy       slave -> master  operation in flight; stall dependents
//   done       slave -> master  one-cycle pulse, HI/LO just updated
//   hi         slave -> master  HI register: product upper half / remainder
//   lo         slave -> master  LO register: product lower half / quotient
// -----------------------------------------------------------------------------
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             is_signed;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, is_signed, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, is_signed, rs_data, rt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// -----------------------------------------------------------------------------
// muldiv_hilo
// Multi-cycle HI/LO multiply/divide unit fed by the register file read ports.
// A shift-add multiplier and a restoring divider share one 2*WIDTH
// accumulator and iterate once per clock for WIDTH cycles. The architectural
// HI/LO registers live here and only change when an operation completes.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any in-flight operation
//   bus    muldiv_hilo_if.slave: start/op/is_signed/rs_data/rt_data in,
//          busy/done/hi/lo out
//
// Timing (accept at edge N):
//   edge N        operands latched, iteration engine starts
//   edges N+1..   one iteration per edge, counter 0..WIDTH-1
//   edge N+W+1    HI/LO written, done pulses for one cycle
//   busy          high from edge N+1 through the done cycle
//
// Build option:
//   SIGNED_MULDIV_EN  when defined, is_signed=1 runs the unsigned core on the
//                     operand magnitudes and corrects the result signs while
//                     HI/LO are written. When undefined is_signed is ignored.
// -----------------------------------------------------------------------------
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_hilo_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  // acc_hi: running product high half / partial remainder
  // acc_lo: multiplier being consumed / dividend shifting into quotient
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // opb: multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             is_div_q, is_div_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;

  // ---------------------------------------------------------------------------
  // Issue acceptance
  // ---------------------------------------------------------------------------
  logic accept;
  logic op_valid;

  assign op_valid = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  // The state is already IDLE during the done pulse; done_q keeps a start in
  // that cycle from being taken so back-to-back issues see one idle cycle.
  assign accept   = (state_q == S_IDLE) && !done_q && bus.start && op_valid;

  // ---------------------------------------------------------------------------
  // Operand magnitudes presented to the unsigned core
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

`ifdef SIGNED_MULDIV_EN
  logic rs_neg;
  logic rt_neg;
  logic neg_a_q;
  logic neg_b_q;

  assign rs_neg = bus.is_signed && bus.rs_data[WIDTH-1];
  assign rt_neg = bus.is_signed && bus.rt_data[WIDTH-1];
  // The most negative value maps onto itself, which is its correct unsigned
  // magnitude, so no special case is needed here.
  assign rs_mag = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
  assign rt_mag = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      neg_a_q <= rs_neg;
      neg_b_q <= rt_neg;
    end
  end
`else
  assign rs_mag = bus.rs_data;
  assign rt_mag = bus.rt_data;
`endif

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Multiply step: conditionally add the multiplicand into the high half, then
  // shift the whole accumulator right; the carry lands in the high bit.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

  // Divide step: bring down the next dividend bit and trial-subtract. The
  // partial remainder stays below the divisor, so the top bit of the
  // difference is a clean borrow flag. A zero divisor never borrows, giving
  // an all-ones quotient and the dividend as remainder.
  logic [WIDTH:0] div_trial;
  logic           div_fits;
  assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opb_q};
  assign div_fits  = !div_trial[WIDTH];

  // ---------------------------------------------------------------------------
  // Final HI/LO values, sign-corrected where enabled
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef SIGNED_MULDIV_EN
  logic [2*WIDTH-1:0] prod_neg;
  assign prod_neg = ~{acc_hi_q, acc_lo_q} + 1'b1;

  always_comb begin
    res_hi = acc_hi_q;
    res_lo = acc_lo_q;
    if (!is_div_q) begin
      if (neg_a_q ^ neg_b_q) begin
        {res_hi, res_lo} = prod_neg;
      end
    end else begin
      // Remainder follows the dividend. For a zero divisor this restores
      // rs_data exactly, including the most negative value.
      if (neg_a_q) begin
        res_hi = ~acc_hi_q + 1'b1;
      end
      // Divide by zero keeps the all-ones quotient regardless of sign.
      if ((neg_a_q ^ neg_b_q) && (opb_q != '0)) begin
        res_lo = ~acc_lo_q + 1'b1;
      end
    end
  end
`else
  assign res_hi = acc_hi_q;
  assign res_lo = acc_lo_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written below gets a default first; any path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    // Registered one edge behind the state so busy rises the edge after
    // acceptance and stays up through the done cycle.
    busy_d   = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          acc_hi_d = '0;
          if (bus.op == OP_MUL) begin
            acc_lo_d = rt_mag;
            opb_d    = rs_mag;
            is_div_d = 1'b0;
            state_d  = S_MUL;
          end else begin
            acc_lo_d = rs_mag;
            opb_d    = rt_mag;
            is_div_d = 1'b1;
            state_d  = S_DIV;
          end
        end
      end

      S_MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DIV: begin
        if (div_fits) begin
          acc_hi_d = div_trial[WIDTH-1:0];
        end else begin
          acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        end
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_fits};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      // NOTE: the accumulator and operand registers are cleared as well even
      // though IDLE never reads them, so nothing in this block powers up X.
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// -----------------------------------------------------------------------------
// tb_muldiv_hilo
// Scoreboard bench for muldiv_hilo (WIDTH=32). Each accepted issue pushes its
// expected HI/LO and accept edge; the done-cycle monitor pops and compares
// result, latency and busy length. Honours SIGNED_MULDIV_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_muldiv_hilo;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;
`ifdef SIGNED_MULDIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          acc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   busy_run = 0;
  exp_t exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_hilo_if #(.WIDTH(W)) bus ();

  muldiv_hilo #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference results from native wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (sgn) begin
      if (op == 2'b01) begin
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        r  = 64'(pa * pb);
      end else if (b == 32'd0) begin
        r = {a, 32'hFFFF_FFFF};
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = {32'h0, 32'h8000_0000};
      end else begin
        int sa, sd;
        sa = $signed(a);
        sd = $signed(b);
        r  = {32'(sa % sd), 32'(sa / sd)};
      end
    end else if (op == 2'b01) begin
      r = 64'(a) * 64'(b);
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // Done-cycle monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      busy_run = bus.busy ? busy_run + 1 : 0;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
          check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
          check({e.tag, "_latency"}, 64'(cyc - e.acc), 64'(LATENCY));
          check({e.tag, "_busy_len"}, 64'(busy_run), 64'(LATENCY));
        end
      end
    end
  end

  task automatic issue(input string tag, input logic [1:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.is_signed = sgn;
    bus.rs_data   = a;
    bus.rt_data   = b;
    if (push) begin
      e.tag = tag; e.acc = cyc + 1; e.hi = eh; e.lo = el;
      exp_q.push_back(e);
      last_hi = eh;
      last_lo = el;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue_model(input string tag, input logic [1:0] op, input logic sgn,
                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = model(op, SIGNED_EN && sgn, a, b);
    issue(tag, op, sgn, a, b, m[63:32], m[31:0], 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t >= 100), 64'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.busy || bus.done) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.is_signed = 1'b0;
    bus.rs_data = '0; bus.rt_data = '0;
    rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived results.
    issue("mul_ffff", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    drain();
    issue("div_100_7", 2'b10, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    drain();
    issue("div_by_0", 2'b10, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Starts while busy and in the done cycle are dropped.
    begin
      int t = 0;
      issue_model("hs_first", 2'b01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01;
      bus.rs_data = 32'h0000_0003; bus.rt_data = 32'h0000_0005;
      @(negedge clk);
      bus.start = 1'b0;
      while (!bus.done && t < 60) begin
        @(negedge clk);
        t++;
      end
      check("hs_done_seen", 64'(t < 60), 64'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      quiet("hs_no_second_op", 40);
    end

    // Operands are captured at accept; later bus changes are ignored.
    issue_model("stable_div", 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (34) begin
      @(negedge clk);
      bus.rs_data = $urandom;
      bus.rt_data = $urandom;
    end
    drain();
    issue_model("stable_mul", 2'b01, 1'b0, 32'hCAFE_F00D, 32'h0BAD_CAFE);
    repeat (34) begin
      @(negedge clk);
      bus.rs_data = $urandom;
      bus.rt_data = $urandom;
    end
    drain();

    // No-op encodings never start the unit and leave HI/LO alone.
    issue("noop_11", 2'b11, 1'b0, 32'h1111_1111, 32'h2222_2222, '0, '0, 1'b0);
    quiet("noop_11_idle", 10);
    check("noop_11_hi", 64'(bus.hi), 64'(last_hi));
    check("noop_11_lo", 64'(bus.lo), 64'(last_lo));
    issue("noop_00", 2'b00, 1'b0, 32'h3333_3333, 32'h4444_4444, '0, '0, 1'b0);
    quiet("noop_00_idle", 10);

`ifdef SIGNED_MULDIV_EN
    issue("sdiv_m7_2",  2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    drain();
    issue("smul_m3_4",  2'b01, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1);
    drain();
    issue("sdiv_min_m1", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    drain();
    issue("sdiv_by_0",  2'b10, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    drain();
`else
    issue("udiv_sgn_ignored", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b1);
    drain();
    issue("umul_sgn_ignored", 2'b01, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'd3, 32'hFFFF_FFF4, 1'b1);
    drain();
`endif

    // Random operations, including a zero divisor and a tiny divisor.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  op;
      logic        sgn;
      logic [31:0] a, b;
      op  = 2'($urandom_range(1, 2));
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i == 3) ? 32'd0 : (i == 4) ? 32'd1 : $urandom;
      if (i == 5) b = b >> 20;
      issue_model($sformatf("rand%0d", i), op, sgn, a, b);
      drain();
    end

    // Asynchronous reset in the middle of a multiply (iteration 10).
    issue("rst_victim", 2'b01, 1'b0, 32'h0F0F_0F0F, 32'h7777_7777, '0, '0, 1'b1);
    repeat (11) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hi",   64'(bus.hi),   64'd0);
    check("async_rst_lo",   64'(bus.lo),   64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet("post_reset_idle", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
